seg7_scan_mux: RTL and testbench

Time-multiplexed 4-digit 7-segment display driver, downstream of the 16-bit `counter`. It takes the 16-bit count value and drives one shared segment bus plus four digit enables, so the whole count is visible on 11 GPIOs. Each digit gets a fixed time slot, with a programmable blanking gap between slots to suppress ghosting. The value is snapshotted once per frame so the display never tears.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/decode_7seg_hex.sv | 22 ++
 rtl/seg7_scan_mux.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_mux.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed 7-segment display path:
//   - HEX_SEG     : 16-entry hex glyph table, bit order g,f,e,d,c,b,a,
//                   active-high (1 = segment lit)
//   - NUM_DIGITS  : number of digits scanned by seg7_scan_mux
//   - phase_e     : per-slot phase of the scan (blanking gap / digit lit)
//   - disp_out_t  : bundle of the registered display outputs
//   - cnt_width() : width of the per-slot cycle counter for a given divider
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NIB_W      = 4;
  localparam int SEG_W      = 7;

  // Glyphs 0-9, A, b, C, d, E, F (same encoding as decode_7seg_hex).
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

  typedef struct packed {
    logic [SEG_W-1:0]      segments;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  frame_tick;
  } disp_out_t;

  // Width of a counter running 0..scan_div-1. The guard keeps the width at
  // least one bit even for an out-of-range divider.
  function automatic int cnt_width(input int scan_div);
    return (scan_div < 2) ? 1 : $clog2(scan_div);
  endfunction

endpackage

// File: rtl/decode_7seg_hex.sv
// ---------------------------------------------------------------------------
// decode_7seg_hex
// Combinational hex-to-7-segment decoder.
// Ports:
//   hex      [3:0] : nibble to decode
//   pol            : 1 = active-high segments, 0 = active-low
//   segments [6:0] : segment pattern, bit order g,f,e,d,c,b,a
// ---------------------------------------------------------------------------
module decode_7seg_hex
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] hex,
  input  logic             pol,
  output logic [SEG_W-1:0] segments
);

  logic [SEG_W-1:0] glyph;

  assign glyph    = HEX_SEG[hex];
  assign segments = pol ? glyph : ~glyph;

endmodule

// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux
// Time-multiplexed 4-digit 7-segment driver. Each digit owns a slot of
// SCAN_DIV cycles; the first BLANK cycles of every slot keep all digits dark
// to suppress ghosting. The displayed value is snapshotted once per frame so
// a frame never mixes two different counts.
//
// Parameters:
//   SCAN_DIV : cycles per digit slot (>= 2)
//   BLANK    : dark cycles at the start of each slot (0 <= BLANK < SCAN_DIV)
// Ports:
//   clk            : clock, all state on the rising edge
//   reset          : asynchronous active-low reset
//   enable         : 1 = scanning, 0 = dark with the scan parked at frame start
//   value    [15:0]: count to display, nibble k on digit k
//   seg_pol        : segment polarity (1 = active-high)
//   dig_pol        : digit-enable polarity (1 = active-high)
//   lz_blank       : 1 = suppress leading zeros (digit 0 always shown)
//   segments [6:0] : shared segment bus, bit order g,f,e,d,c,b,a
//   digit_en [3:0] : one-hot digit select, bit k = digit k
//   frame_tick     : one-cycle pulse aligned with the first output cycle of
//                    a new frame
// ---------------------------------------------------------------------------
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
  parameter int BLANK    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_DIGITS*NIB_W-1:0] value,
  input  logic                        seg_pol,
  input  logic                        dig_pol,
  input  logic                        lz_blank,
  output logic [SEG_W-1:0]            segments,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        frame_tick
);

  localparam int DIV_W = cnt_width(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = NUM_DIGITS * NIB_W;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK);

  // Scan state
  logic [DIV_W-1:0] div_cnt,  div_cnt_nxt;
  logic [IDX_W-1:0] dig_idx,  dig_idx_nxt;
  logic [VAL_W-1:0] snap,     snap_nxt;

  // Per-cycle decode of the scan state
  logic             frame_load;
  phase_e           phase;
  logic             lead_zero;
  logic             lit;
  logic [NIB_W-1:0] cur_nib;
  logic [SEG_W-1:0] glyph;
  logic [NUM_DIGITS-1:0] one_hot;

  disp_out_t        out_nxt, out_q;

  // -------------------------------------------------------------------------
  // Slot / digit counters and frame snapshot
  // -------------------------------------------------------------------------
  // A new frame begins whenever the scan sits at digit 0, cycle 0 while
  // enabled; a disabled scan is parked there, so re-enabling starts a frame.
  assign frame_load = enable && (div_cnt == '0) && (dig_idx == '0);

  // NOTE: every signal written here gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    div_cnt_nxt = div_cnt;
    dig_idx_nxt = dig_idx;
    snap_nxt    = snap;

    if (!enable) begin
      div_cnt_nxt = '0;
      dig_idx_nxt = '0;
    end else begin
      if (frame_load) begin
        snap_nxt = value;
      end
      if (div_cnt == DIV_LAST) begin
        div_cnt_nxt = '0;
        // NUM_DIGITS is a power of two, so 3 -> 0 is the natural wrap.
        dig_idx_nxt = dig_idx + 1'b1;
      end else begin
        div_cnt_nxt = div_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (one cycle ahead of the pins)
  // -------------------------------------------------------------------------
  assign phase = (div_cnt >= BLANK_END) ? PH_SHOW : PH_BLANK;

  // Decode from the value the snapshot holds after this edge, so the first
  // cycle of a frame already shows the new count even when BLANK is 0.
  assign cur_nib = snap_nxt[{dig_idx, 2'b00} +: NIB_W];

  // Digit k is a leading zero when nibbles k..3 are all zero, i.e. the value
  // shifted down by k nibbles is zero. Digit 0 is never suppressed.
  assign lead_zero = (dig_idx != '0) && ((snap_nxt >> {dig_idx, 2'b00}) == '0);

  assign lit     = enable && (phase == PH_SHOW) && !(lz_blank && lead_zero);
  assign one_hot = NUM_DIGITS'(1) << dig_idx;

  decode_7seg_hex u_decode (
    .hex      (cur_nib),
    .pol      (1'b1),
    .segments (glyph)
  );

  always_comb begin
    out_nxt.segments   = {SEG_W{~seg_pol}};
    out_nxt.digit_en   = {NUM_DIGITS{~dig_pol}};
    out_nxt.frame_tick = frame_load;

    if (lit) begin
      out_nxt.segments = seg_pol ? glyph   : ~glyph;
      out_nxt.digit_en = dig_pol ? one_hot : ~one_hot;
    end
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      dig_idx <= '0;
      snap    <= '0;
      out_q   <= '0;
    end else begin
      div_cnt <= div_cnt_nxt;
      dig_idx <= dig_idx_nxt;
      snap    <= snap_nxt;
      out_q   <= out_nxt;
    end
  end

  assign segments   = out_q.segments;
  assign digit_en   = out_q.digit_en;
  assign frame_tick = out_q.frame_tick;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_mux
// Directed bench for seg7_scan_mux with SCAN_DIV = 8, BLANK = 2.
// Output cycle n counts from the first edge of a frame: digit n/8 % 4,
// position n % 8 within its slot, dark while position < 2.
// ---------------------------------------------------------------------------
module tb_seg7_scan_mux;

  localparam int SD = 8;
  localparam int BL = 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic        seg_pol;
  logic        dig_pol;
  logic        lz_blank;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_tick;

  int checks;
  int errors;

  seg7_scan_mux #(
    .SCAN_DIV (SD),
    .BLANK    (BL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .value      (value),
    .seg_pol    (seg_pol),
    .dig_pol    (dig_pol),
    .lz_blank   (lz_blank),
    .segments   (segments),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written glyph table, active-high, g..a.
  function automatic logic [6:0] tb_hex(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  // Expected segment bus at frame cycle n; lit[d] = digit d is not a
  // suppressed leading zero (mask chosen by hand per test).
  function automatic logic [6:0] exp_seg(input int n, input logic [15:0] v,
                                         input logic [3:0] lit, input logic sp);
    int d;
    int p;
    logic [6:0] raw;
    d = (n / SD) % 4;
    p = n % SD;
    if (p < BL || !lit[d]) return {7{~sp}};
    raw = tb_hex(v[d*4 +: 4]);
    return sp ? raw : ~raw;
  endfunction

  function automatic logic [3:0] exp_dig(input int n, input logic [3:0] lit,
                                         input logic dp);
    int d;
    int p;
    logic [3:0] oh;
    d  = (n / SD) % 4;
    p  = n % SD;
    oh = 4'b0001 << d;
    if (p < BL || !lit[d]) return {4{~dp}};
    return dp ? oh : ~oh;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Park the scan at frame start; the next tick() yields frame cycle 0.
  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    enable   = 1'b1;
    seg_pol  = 1'b1;
    dig_pol  = 1'b1;
    lz_blank = 1'b0;
    value    = 16'h1234;
    #2;
    checks++;
    if ({segments, digit_en, frame_tick} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got %h want 000", {segments, digit_en, frame_tick});
    end
    @(negedge clk);
    reset = 1'b1;
    // Run into digit 1's lit window.
    for (int n = 0; n < 13; n++) begin
      tick();
      checks++;
      if (digit_en !== exp_dig(n, 4'hF, 1'b1)) begin
        errors++;
        $display("FAIL reset_run_dig n=%0d got %b want %b", n, digit_en, exp_dig(n, 4'hF, 1'b1));
      end
      checks++;
      if (segments !== exp_seg(n, 16'h1234, 4'hF, 1'b1)) begin
        errors++;
        $display("FAIL reset_run_seg n=%0d got %b want %b", n, segments, exp_seg(n, 16'h1234, 4'hF, 1'b1));
      end
    end
    // Asynchronous assertion mid-slot, well away from any clock edge.
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({segments, digit_en, frame_tick} !== 12'h000) begin
      errors++;
      $display("FAIL reset_async got %h want 000", {segments, digit_en, frame_tick});
    end
    tick();
    checks++;
    if ({segments, digit_en, frame_tick} !== 12'h000) begin
      errors++;
      $display("FAIL reset_held got %h want 000", {segments, digit_en, frame_tick});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (frame_tick !== (n == 0)) begin
        errors++;
        $display("FAIL reset_tick n=%0d got %b want %b", n, frame_tick, (n == 0));
      end
      checks++;
      if (digit_en !== ((n < 2) ? 4'b0000 : 4'b0001)) begin
        errors++;
        $display("FAIL reset_dig n=%0d got %b want %b", n, digit_en, ((n < 2) ? 4'b0000 : 4'b0001));
      end
      checks++;
      if (segments !== ((n < 2) ? 7'b0000000 : 7'b1100110)) begin
        errors++;
        $display("FAIL reset_seg n=%0d got %b want %b", n, segments, ((n < 2) ? 7'b0000000 : 7'b1100110));
      end
    end
  endtask

  task automatic test_scan_order();
    value   = 16'h1234;
    seg_pol = 1'b1;
    dig_pol = 1'b1;
    restart();
    // 33 cycles: one full frame plus the start of the next (32-cycle period).
    for (int n = 0; n < 33; n++) begin
      tick();
      checks++;
      if (frame_tick !== (n % 32 == 0)) begin
        errors++;
        $display("FAIL scan_tick n=%0d got %b want %b", n, frame_tick, (n % 32 == 0));
      end
      checks++;
      if (digit_en !== exp_dig(n, 4'hF, 1'b1)) begin
        errors++;
        $display("FAIL scan_dig n=%0d got %b want %b", n, digit_en, exp_dig(n, 4'hF, 1'b1));
      end
      checks++;
      if (segments !== exp_seg(n, 16'h1234, 4'hF, 1'b1)) begin
        errors++;
        $display("FAIL scan_seg n=%0d got %b want %b", n, segments, exp_seg(n, 16'h1234, 4'hF, 1'b1));
      end
    end
  endtask

  task automatic test_tearing();
    logic [15:0] v_exp;
    value = 16'h1234;
    restart();
    for (int n = 0; n < 64; n++) begin
      tick();
      v_exp = (n < 32) ? 16'h1234 : 16'hABCD;
      checks++;
      if (digit_en !== exp_dig(n, 4'hF, 1'b1)) begin
        errors++;
        $display("FAIL tear_dig n=%0d got %b want %b", n, digit_en, exp_dig(n, 4'hF, 1'b1));
      end
      checks++;
      if (segments !== exp_seg(n, v_exp, 4'hF, 1'b1)) begin
        errors++;
        $display("FAIL tear_seg n=%0d got %b want %b", n, segments, exp_seg(n, v_exp, 4'hF, 1'b1));
      end
      // Change the input while digit 2 is lit.
      if (n == 19) value = 16'hABCD;
    end
  endtask

  task automatic test_leading_zeros();
    lz_blank = 1'b1;
    value    = 16'h0042;
    restart();
    for (int n = 0; n < 32; n++) begin
      tick();
      checks++;
      if (digit_en !== exp_dig(n, 4'b0011, 1'b1)) begin
        errors++;
        $display("FAIL lz42_dig n=%0d got %b want %b", n, digit_en, exp_dig(n, 4'b0011, 1'b1));
      end
      checks++;
      if (segments !== exp_seg(n, 16'h0042, 4'b0011, 1'b1)) begin
        errors++;
        $display("FAIL lz42_seg n=%0d got %b want %b", n, segments, exp_seg(n, 16'h0042, 4'b0011, 1'b1));
      end
    end
    value = 16'h0000;
    restart();
    for (int n = 0; n < 32; n++) begin
      tick();
      checks++;
      if (digit_en !== exp_dig(n, 4'b0001, 1'b1)) begin
        errors++;
        $display("FAIL lz0_dig n=%0d got %b want %b", n, digit_en, exp_dig(n, 4'b0001, 1'b1));
      end
      checks++;
      if (segments !== exp_seg(n, 16'h0000, 4'b0001, 1'b1)) begin
        errors++;
        $display("FAIL lz0_seg n=%0d got %b want %b", n, segments, exp_seg(n, 16'h0000, 4'b0001, 1'b1));
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_polarity();
    seg_pol = 1'b0;
    dig_pol = 1'b0;
    value   = 16'h8888;
    restart();
    for (int n = 0; n < 32; n++) begin
      tick();
      checks++;
      if (digit_en !== exp_dig(n, 4'hF, 1'b0)) begin
        errors++;
        $display("FAIL pol_dig n=%0d got %b want %b", n, digit_en, exp_dig(n, 4'hF, 1'b0));
      end
      checks++;
      if (segments !== exp_seg(n, 16'h8888, 4'hF, 1'b0)) begin
        errors++;
        $display("FAIL pol_seg n=%0d got %b want %b", n, segments, exp_seg(n, 16'h8888, 4'hF, 1'b0));
      end
    end
  endtask

  task automatic test_enable();
    seg_pol = 1'b1;
    dig_pol = 1'b0;
    value   = 16'h1234;
    restart();
    for (int n = 0; n < 21; n++) begin
      tick();
      checks++;
      if (digit_en !== exp_dig(n, 4'hF, 1'b0)) begin
        errors++;
        $display("FAIL en_run_dig n=%0d got %b want %b", n, digit_en, exp_dig(n, 4'hF, 1'b0));
      end
    end
    // Drop enable while digit 2 is lit; off level is seg 00, digits F.
    enable = 1'b0;
    value  = 16'h5678;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({segments, digit_en, frame_tick} !== {7'h00, 4'hF, 1'b0}) begin
        errors++;
        $display("FAIL en_off k=%0d got %h want %h", k, {segments, digit_en, frame_tick}, {7'h00, 4'hF, 1'b0});
      end
    end
    enable = 1'b1;
    for (int n = 0; n < 32; n++) begin
      tick();
      checks++;
      if (frame_tick !== (n == 0)) begin
        errors++;
        $display("FAIL en_tick n=%0d got %b want %b", n, frame_tick, (n == 0));
      end
      checks++;
      if (digit_en !== exp_dig(n, 4'hF, 1'b0)) begin
        errors++;
        $display("FAIL en_dig n=%0d got %b want %b", n, digit_en, exp_dig(n, 4'hF, 1'b0));
      end
      checks++;
      if (segments !== exp_seg(n, 16'h5678, 4'hF, 1'b1)) begin
        errors++;
        $display("FAIL en_seg n=%0d got %b want %b", n, segments, exp_seg(n, 16'h5678, 4'hF, 1'b1));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_scan_order();
    test_tearing();
    test_leading_zeros();
    test_polarity();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
